sqrt_iter: RTL and testbench

Parametrised iterative integer square-root unit, successor to the fixed 18-bit sqrt block. It computes one result bit per clock instead of one per two clocks. It also returns the remainder and can round to nearest (with saturation) as well as floor. It uses the same start/busy handshake plus a one-cycle done pulse, and sits beside the other functional-circuitry arithmetic blocks.

---
 rtl/sqrt_pkg.sv | 18 +
 rtl/sqrt_step.sv | 28 ++
 rtl/sqrt_iter.sv | 121 ++++++++++++
 tb/tb_sqrt_iter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// Shared types and constants for the iterative square-root unit.
package sqrt_pkg;

    // IDLE is all-zero so "busy" is simply the OR of the state bits.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int ROUND_FLOOR   = 0;
    localparam int ROUND_NEAREST = 1;

    function automatic int cnt_width(input int yw);
        return (yw < 1) ? 1 : $clog2(yw + 1);
    endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring square-root iteration: trial-subtract (res | m) from the partial remainder.
module sqrt_step #(
    parameter int XW = 18
) (
    input  logic [XW-1:0] x,
    input  logic [XW-1:0] res,
    input  logic [XW-2:0] m,
    output logic [XW-1:0] x_next,
    output logic [XW-1:0] res_next
);

    logic [XW-1:0] m_ext;
    logic [XW-1:0] b;

    // m never overlaps a set bit of res, so OR is the same as the add.
    assign m_ext = {1'b0, m};
    assign b     = res | m_ext;

    always_comb begin
        x_next   = x;
        res_next = res >> 1;
        if (x >= b) begin
            x_next   = x - b;
            res_next = (res >> 1) | m_ext;
        end
    end

endmodule

// File: rtl/sqrt_iter.sv
// Iterative integer square root, one root bit per clock, with remainder and optional rounding.
module sqrt_iter
    import sqrt_pkg::*;
#(
    parameter int XW    = 18,
    parameter int ROUND = ROUND_FLOOR
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [XW-1:0]   x_bi,
    output logic [XW/2-1:0] y_bo,
    output logic [XW/2:0]   rem_bo,
    output logic            sat_o,
    output logic            busy_o,
    output logic            done_o,
    output state_t          state_o
);

    localparam int YW = XW / 2;
    localparam int CW = cnt_width(YW);

    state_t        state_q;
    state_t        state_d;
    logic [XW-1:0] x_q;
    logic [XW-1:0] res_q;
    logic [XW-2:0] m_q;
    logic [CW-1:0] cnt_q;
    logic [XW-1:0] x_next;
    logic [XW-1:0] res_next;
    logic          last_iter;

    logic [YW-1:0] r;
    logic [YW:0]   rem;
    logic [YW-1:0] y_fin;
    logic          y_sat;

    sqrt_step #(.XW(XW)) u_step (
        .x        (x_q),
        .res      (res_q),
        .m        (m_q),
        .x_next   (x_next),
        .res_next (res_next)
    );

    assign last_iter = (cnt_q == CW'(YW - 1));
    assign busy_o    = |state_q;
    assign state_o   = state_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = CALC;
            CALC:    if (last_iter) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Round up only when the remainder exceeds r, i.e. x >= r^2 + r + 1.
    always_comb begin
        r     = res_q[YW-1:0];
        rem   = x_q[YW:0];
        y_fin = r;
        y_sat = 1'b0;
        if (ROUND == ROUND_NEAREST && rem > {1'b0, r}) begin
            if (&r) begin
                y_sat = 1'b1;
            end else begin
                y_fin = r + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q    <= '0;
            res_q  <= '0;
            m_q    <= '0;
            cnt_q  <= '0;
            y_bo   <= '0;
            rem_bo <= '0;
            sat_o  <= 1'b0;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        x_q   <= x_bi;
                        res_q <= '0;
                        m_q   <= {1'b1, {(XW-2){1'b0}}};
                        cnt_q <= '0;
                    end
                end
                CALC: begin
                    x_q   <= x_next;
                    res_q <= res_next;
                    m_q   <= m_q >> 2;
                    cnt_q <= cnt_q + 1'b1;
                end
                FINISH: begin
                    y_bo   <= y_fin;
                    rem_bo <= rem;
                    sat_o  <= y_sat;
                    done_o <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_iter.sv
// Bench for sqrt_iter: floor and rounding 18-bit instances plus an exhaustive 8-bit instance.
module tb_sqrt_iter;
    import sqrt_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic [17:0] x0 = '0, x1 = '0;
    logic [7:0]  x2 = '0;
    logic [8:0]  y0, y1;
    logic [9:0]  rem0, rem1;
    logic [3:0]  y2;
    logic [4:0]  rem2;
    logic        sat0, sat1, sat2, busy0, busy1, busy2, done0, done1, done2;
    state_t      st0, st1, st2;

    int errors = 0;
    int checks = 0;

    sqrt_iter #(.XW(18), .ROUND(ROUND_FLOOR)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start0), .x_bi(x0), .y_bo(y0), .rem_bo(rem0),
        .sat_o(sat0), .busy_o(busy0), .done_o(done0), .state_o(st0));
    sqrt_iter #(.XW(18), .ROUND(ROUND_NEAREST)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .x_bi(x1), .y_bo(y1), .rem_bo(rem1),
        .sat_o(sat1), .busy_o(busy1), .done_o(done1), .state_o(st1));
    sqrt_iter #(.XW(8), .ROUND(ROUND_FLOOR)) dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .x_bi(x2), .y_bo(y2), .rem_bo(rem2),
        .sat_o(sat2), .busy_o(busy2), .done_o(done2), .state_o(st2));

    typedef struct {
        int          which;
        logic [17:0] x;
        logic [17:0] y;
        logic [17:0] rem;
        logic        sat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [17:0] get_y(input int w);
        case (w)
            0:       return 18'(y0);
            1:       return 18'(y1);
            default: return 18'(y2);
        endcase
    endfunction

    function automatic logic [17:0] get_rem(input int w);
        case (w)
            0:       return 18'(rem0);
            1:       return 18'(rem1);
            default: return 18'(rem2);
        endcase
    endfunction

    function automatic logic get_sat(input int w);
        return (w == 0) ? sat0 : (w == 1) ? sat1 : sat2;
    endfunction

    function automatic logic get_done(input int w);
        return (w == 0) ? done0 : (w == 1) ? done1 : done2;
    endfunction

    function automatic logic get_busy(input int w);
        return (w == 0) ? busy0 : (w == 1) ? busy1 : busy2;
    endfunction

    function automatic int yw_of(input int w);
        return (w == 2) ? 4 : 9;
    endfunction

    task automatic set_start(input int w, input logic v, input logic [17:0] xin);
        case (w)
            0:       begin start0 = v; x0 = xin; end
            1:       begin start1 = v; x1 = xin; end
            default: begin start2 = v; x2 = xin[7:0]; end
        endcase
    endtask

    // Called #1 after an edge; returns #1 after the accepting edge E0.
    task automatic start_op(input int w, input logic [17:0] xin);
        set_start(w, 1'b1, xin);
        @(posedge clk);
        #1;
        case (w)
            0:       start0 = 1'b0;
            1:       start1 = 1'b0;
            default: start2 = 1'b0;
        endcase
    endtask

    // lat counts edges after E0 until done_o is seen.
    task automatic wait_done(input int w, output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (get_busy(w)) busy_cnt++;
            if (get_done(w)) break;
        end
        if (!get_done(w)) begin
            errors++;
            $display("FAIL timeout: dut%0d no done within %0d cycles", w, lat);
        end
    endtask

    task automatic run_vec(input int w, input logic [17:0] xin, input logic [17:0] ey,
                           input logic [17:0] erem, input logic esat);
        int lat, bc;
        start_op(w, xin);
        wait_done(w, lat, bc);
        check($sformatf("latency dut%0d x=%0d", w, xin), lat, yw_of(w) + 1);
        check($sformatf("y dut%0d x=%0d", w, xin), get_y(w), ey);
        check($sformatf("rem dut%0d x=%0d", w, xin), get_rem(w), erem);
        check($sformatf("sat dut%0d x=%0d", w, xin), get_sat(w), esat);
        if (w != 2) begin
            check($sformatf("busy cycles dut%0d x=%0d", w, xin), bc, yw_of(w));
        end
        @(posedge clk);
        #1;
        check($sformatf("done single dut%0d x=%0d", w, xin), get_done(w), 1'b0);
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bc, dcount, nd, r;

        vecs[0]  = '{0, 18'd0,      18'd0,   18'd0,    1'b0};
        vecs[1]  = '{0, 18'd144,    18'd12,  18'd0,    1'b0};
        vecs[2]  = '{0, 18'd156,    18'd12,  18'd12,   1'b0};
        vecs[3]  = '{0, 18'd157,    18'd12,  18'd13,   1'b0};
        vecs[4]  = '{0, 18'd262143, 18'd511, 18'd1022, 1'b0};
        vecs[5]  = '{0, 18'd1000,   18'd31,  18'd39,   1'b0};
        vecs[6]  = '{1, 18'd156,    18'd12,  18'd12,   1'b0};
        vecs[7]  = '{1, 18'd157,    18'd13,  18'd13,   1'b0};
        vecs[8]  = '{1, 18'd262143, 18'd511, 18'd1022, 1'b1};
        vecs[9]  = '{1, 18'd261632, 18'd511, 18'd511,  1'b0};
        vecs[10] = '{1, 18'd1000,   18'd32,  18'd39,   1'b0};
        vecs[11] = '{1, 18'd0,      18'd0,   18'd0,    1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset y0", y0, 0);
        check("reset rem0", rem0, 0);
        check("reset sat0", sat0, 0);
        check("reset done0", done0, 0);
        check("reset busy0", busy0, 0);
        check("reset state0", st0, IDLE);
        check("reset busy1", busy1, 0);
        check("reset y2", y2, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i].which, vecs[i].x, vecs[i].y, vecs[i].rem, vecs[i].sat);
        end

        // Mid-run start with a new operand must be ignored.
        start_op(0, 18'd144);
        lat = 0;
        dcount = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            lat = c;
            if (c == 3) set_start(0, 1'b1, 18'd9);
            if (c == 5) start0 = 1'b0;
            if (done0) begin
                dcount++;
                break;
            end
        end
        check("midrun done count", dcount, 1);
        check("midrun latency", lat, 10);
        check("midrun y", y0, 12);
        check("midrun rem", rem0, 0);

        // Start in the done cycle is accepted immediately.
        start_op(0, 18'd9);
        wait_done(0, lat, bc);
        check("b2b latency", lat, 10);
        check("b2b y", y0, 3);
        check("b2b rem", rem0, 0);

        // Reset during iteration 4 aborts with no done pulse.
        @(posedge clk);
        #1;
        start_op(0, 18'd1000);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort done", done0, 0);
        check("abort y", y0, 0);
        check("abort rem", rem0, 0);
        check("abort sat", sat0, 0);
        check("abort busy", busy0, 0);
        nd = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done0) nd++;
        end
        check("abort no late done", nd, 0);
        run_vec(0, 18'd1000, 18'd31, 18'd39, 1'b0);

        for (int xv = 0; xv < 256; xv++) begin
            r = 0;
            while ((r + 1) * (r + 1) <= xv) r++;
            run_vec(2, 18'(xv), 18'(r), 18'(xv - r * r), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
